// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and round-robin pick helper for the adder arbiter
package adder_arb_pkg;

  // Tags are sized for the largest supported requester count so one type serves every instance.
  localparam int max_req = 8;
  localparam int tag_w   = $clog2(max_req);

  typedef logic [tag_w-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t grant;
  } pick_t;

  function automatic pick_t rr_pick(input logic [max_req-1:0] vld, input tag_t ptr, input int n);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = 0; k < max_req; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !res.found && vld[tag_t'(idx)]) begin
        res.found = 1'b1;
        res.grant = tag_t'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_arb_tag_fifo.sv
// rtl/adder_arb_tag_fifo.sv - synchronous FIFO of requester tags in issue order
module adder_arb_tag_fifo
  import adder_arb_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  tag_t                         push_tag,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output tag_t                         head,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth+1);

  tag_t             mem_q [depth];
  tag_t             mem_d [depth];
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + ptr_w'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + ptr_w'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == cnt_w'(depth));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin sharing of one flow-controlled adder among n_req requesters
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int n_req     = 4,
  parameter int width     = 8,
  parameter int tag_depth = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [n_req-1:0]               req_vld,
  output logic [n_req-1:0]               req_rdy,
  input  logic [n_req*width-1:0]         req_a,
  input  logic [n_req*width-1:0]         req_b,
  output logic [n_req-1:0]               rsp_vld,
  input  logic [n_req-1:0]               rsp_rdy,
  output logic [width:0]                 rsp_sum,
  output logic                           a_vld,
  input  logic                           a_rdy,
  output logic [width-1:0]               a_data,
  output logic                           b_vld,
  input  logic                           b_rdy,
  output logic [width-1:0]               b_data,
  input  logic                           sum_vld,
  output logic                           sum_rdy,
  input  logic [width:0]                 sum_data,
  output logic [$clog2(tag_depth+1)-1:0] outstanding
);

  logic [width-1:0] a_q, a_d, b_q, b_d;
  logic             slot_vld_q, slot_vld_d;
  logic             a_sent_q, a_sent_d, b_sent_q, b_sent_d;
  tag_t             rr_ptr_q, rr_ptr_d;

  logic               a_hs, b_hs, slot_free, load, pop;
  logic               fifo_full, tag_empty, tag_full;
  tag_t               head;
  pick_t              pick;
  logic [max_req-1:0] vld_ext, rsp_rdy_ext;

  assign vld_ext     = max_req'(req_vld);
  assign rsp_rdy_ext = max_req'(rsp_rdy);

  always_comb begin
    a_vld     = slot_vld_q & ~a_sent_q;
    b_vld     = slot_vld_q & ~b_sent_q;
    a_hs      = a_vld & a_rdy;
    b_hs      = b_vld & b_rdy;
    slot_free = ~slot_vld_q | ((a_sent_q | a_hs) & (b_sent_q | b_hs));
    sum_rdy   = ~tag_empty & rsp_rdy_ext[head];
    pop       = sum_vld & sum_rdy;
    // A pop in the same cycle makes room, so a full FIFO can still accept.
    tag_full  = fifo_full & ~pop;
    pick      = rr_pick(vld_ext, rr_ptr_q, n_req);
    load      = slot_free & ~tag_full & pick.found;
    req_rdy   = '0;
    rsp_vld   = '0;
    for (int i = 0; i < n_req; i++) begin
      req_rdy[i] = load & (pick.grant == tag_t'(i));
      rsp_vld[i] = sum_vld & ~tag_empty & (head == tag_t'(i));
    end
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    slot_vld_d = slot_vld_q;
    a_sent_d   = a_sent_q;
    b_sent_d   = b_sent_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      a_d        = req_a[int'(pick.grant)*width +: width];
      b_d        = req_b[int'(pick.grant)*width +: width];
      slot_vld_d = 1'b1;
      a_sent_d   = 1'b0;
      b_sent_d   = 1'b0;
      rr_ptr_d   = (int'(pick.grant) == n_req-1) ? '0 : pick.grant + tag_t'(1);
    end else if (slot_free) begin
      slot_vld_d = 1'b0;
      a_sent_d   = 1'b0;
      b_sent_d   = 1'b0;
    end else begin
      a_sent_d   = a_sent_q | a_hs;
      b_sent_d   = b_sent_q | b_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      slot_vld_q <= 1'b0;
      a_sent_q   <= 1'b0;
      b_sent_q   <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      slot_vld_q <= slot_vld_d;
      a_sent_q   <= a_sent_d;
      b_sent_q   <= b_sent_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign a_data  = a_q;
  assign b_data  = b_q;
  assign rsp_sum = sum_data;

  adder_arb_tag_fifo #(.depth(tag_depth)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (load),
    .push_tag (pick.grant),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (tag_empty),
    .head     (head),
    .count    (outstanding)
  );

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed self-checking bench for adder_rr_arbiter with a buffered adder model
module tb_adder_rr_arbiter;

  localparam int n_req     = 4;
  localparam int width     = 8;
  localparam int tag_depth = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [n_req-1:0]       req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [n_req*width-1:0] req_a, req_b;
  logic [width:0]         rsp_sum;
  logic                   a_vld, a_rdy, b_vld, b_rdy, sum_vld, sum_rdy;
  logic [width-1:0]       a_data, b_data;
  logic [width:0]         sum_data;
  logic [2:0]             outstanding;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.n_req(n_req), .width(width), .tag_depth(tag_depth)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_sum(rsp_sum),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data),
    .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data),
    .outstanding(outstanding)
  );

  // Adder model: one-deep a/b holding registers and a 4-deep in-order sum queue.
  logic       a_en, b_en, af, bf, fire, spop;
  logic [7:0] ah, bh;
  logic [8:0] sq [4];
  logic [1:0] wp, rp;
  logic [2:0] sc;

  assign a_rdy    = a_en & ~af;
  assign b_rdy    = b_en & ~bf;
  assign fire     = af & bf & (sc != 3'd4);
  assign sum_vld  = (sc != 3'd0);
  assign sum_data = sq[rp];
  assign spop     = sum_vld & sum_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af <= 1'b0; bf <= 1'b0; wp <= '0; rp <= '0; sc <= '0;
    end else begin
      if (a_vld && a_rdy) begin af <= 1'b1; ah <= a_data; end
      else if (fire) af <= 1'b0;
      if (b_vld && b_rdy) begin bf <= 1'b1; bh <= b_data; end
      else if (fire) bf <= 1'b0;
      if (fire) begin sq[wp] <= {1'b0, ah} + {1'b0, bh}; wp <= wp + 2'd1; end
      if (spop) rp <= rp + 2'd1;
      sc <= sc + {2'b0, fire} - {2'b0, spop};
    end
  end

  int         chk_cnt = 0, pass_cnt = 0;
  logic [7:0] op_a [n_req][16];
  logic [7:0] op_b [n_req][16];
  int         ncnt [n_req], sent [n_req], rcv [n_req];
  int         glog [64];
  int         gn = 0, rsp_total = 0, oh_req_err = 0, oh_rsp_err = 0, perr = 0;
  logic [8:0] last_sum = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_op(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i][ncnt[i]] = a;
    op_b[i][ncnt[i]] = b;
    ncnt[i]++;
  endtask

  function automatic bit idle_f();
    for (int i = 0; i < n_req; i++)
      if (sent[i] != ncnt[i] || rcv[i] != sent[i]) return 1'b0;
    return (outstanding == 3'd0) && !sum_vld;
  endfunction

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!idle_f() && c < budget) begin tick(); c++; end
    check("idle_wait", 32'(idle_f()), 32'd1);
  endtask

  task automatic wait_out(input int n, input int budget);
    int c = 0;
    while (int'(outstanding) != n && c < budget) begin tick(); c++; end
    check("outstanding_wait", 32'(outstanding), 32'(n));
  endtask

  // Requester driver: presents each requester's next queued pair, updated just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < n_req; i++) begin
        req_vld[i]             = (sent[i] < ncnt[i]);
        req_a[i*width +: width] = (sent[i] < ncnt[i]) ? op_a[i][sent[i]] : 8'h00;
        req_b[i*width +: width] = (sent[i] < ncnt[i]) ? op_b[i][sent[i]] : 8'h00;
      end
    end
  end

  // Monitor: records accepts and responses; each returned sum is checked against its own operands.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(req_rdy) > 1) oh_req_err++;
      if ($countones(rsp_vld) > 1) oh_rsp_err++;
      if (sum_vld && outstanding == 3'd0) perr++;
      for (int i = 0; i < n_req; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          if (gn < 64) glog[gn] = i;
          gn++;
          sent[i]++;
        end
        if (rsp_vld[i]) begin
          rsp_total++;
          if (rsp_rdy[i]) begin
            check("rsp_sum", 32'(rsp_sum), 32'(op_a[i][rcv[i]]) + 32'(op_b[i][rcv[i]]));
            last_sum = rsp_sum;
            rcv[i]++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i < n_req; i++) begin ncnt[i] = 0; sent[i] = 0; rcv[i] = 0; end
    rst_n = 1'b0; a_en = 1'b1; b_en = 1'b1; rsp_rdy = '1;
    req_vld = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_a_vld", 32'(a_vld), 32'd0);
    check("rst_b_vld", 32'(b_vld), 32'd0);
    check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("rst_sum_rdy", 32'(sum_rdy), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: every requester holds two pairs.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < n_req; i++)
        add_op(i, 8'(16*i + k), 8'(32 + 3*i + k));
    wait_idle(300);
    for (int k = 0; k < 8; k++) check("grant_order", 32'(glog[k]), 32'(k % 4));

    // Single requester.
    t0 = rsp_total;
    add_op(2, 8'h05, 8'h07);
    wait_idle(100);
    check("single_sum", 32'(last_sum), 32'h00C);
    check("single_only", 32'(rsp_total - t0), 32'd1);
    check("single_outstanding", 32'(outstanding), 32'd0);

    // Carry into the extra sum bit.
    add_op(0, 8'hFF, 8'hFF);
    wait_idle(100);
    check("ovf_sum", 32'(last_sum), 32'h1FE);

    // b port stalled while a is accepted: slot must hold and block new grants.
    b_en = 1'b0;
    add_op(1, 8'h12, 8'h34);
    add_op(3, 8'h80, 8'h81);
    tick(); tick(); tick();
    for (int c = 0; c < 5; c++) begin
      check("skew_a_vld", 32'(a_vld), 32'd0);
      check("skew_b_vld", 32'(b_vld), 32'd1);
      check("skew_req_rdy", 32'(req_rdy), 32'd0);
      tick();
    end
    b_en = 1'b1;
    wait_idle(100);
    check("skew_last_sum", 32'(last_sum), 32'h101);

    // Stalled consumer fills the tag FIFO.
    rsp_rdy[1] = 1'b0;
    for (int k = 0; k < 6; k++) add_op(1, 8'(8'h40 + k), 8'(8'hC0 + 2*k));
    wait_out(tag_depth, 100);
    for (int c = 0; c < 4; c++) begin
      check("bp_req_rdy", 32'(req_rdy), 32'd0);
      check("bp_outstanding", 32'(outstanding), 32'(tag_depth));
      tick();
    end
    rsp_rdy[1] = 1'b1;
    wait_idle(300);

    // Asynchronous reset with three operations in flight.
    rsp_rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) add_op(0, 8'(8'h11 * (k + 1)), 8'h01);
    wait_out(3, 100);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_a_vld", 32'(a_vld), 32'd0);
    check("mid_rst_b_vld", 32'(b_vld), 32'd0);
    check("mid_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("mid_rst_sum_rdy", 32'(sum_rdy), 32'd0);
    check("mid_rst_outstanding", 32'(outstanding), 32'd0);
    for (int i = 0; i < n_req; i++) begin ncnt[i] = sent[i]; rcv[i] = sent[i]; end
    rsp_rdy = '1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    add_op(2, 8'h3C, 8'h5A);
    wait_idle(100);
    check("post_rst_sum", 32'(last_sum), 32'h096);

    check("onehot_req_rdy", 32'(oh_req_err), 32'd0);
    check("onehot_rsp_vld", 32'(oh_rsp_err), 32'd0);
    check("sum_without_tag", 32'(perr), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one adder_with_flow_control instance among n_req requesters.
- Each requester offers an (a, b) operand pair on a valid/ready handshake. A round-robin grant selects one pair per issue, and a registered issue slot presents a and b to the adder's independent a/b ports.
- A tag FIFO records the requester order so that each returning sum is steered back to its originating requester.

Parameters:
- n_req, 4, number of requesters (2..8).
- width, 8, operand width; must equal the adder's width.
- tag_depth, 4, maximum outstanding operations in flight (power of 2, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  n_req  per-requester operand-pair valid.
- req_rdy  out  n_req  per-requester accept.
- req_a  in  n_req*width  packed operand a; requester i uses slice [i*width +: width].
- req_b  in  n_req*width  packed operand b, same packing.
- rsp_vld  out  n_req  per-requester sum valid.
- rsp_rdy  in  n_req  per-requester sum accept.
- rsp_sum  out  width+1  shared sum bus; meaningful only for the requester with rsp_vld high.
- a_vld / a_rdy / a_data  out / in / out  1 / 1 / width  to the adder a port.
- b_vld / b_rdy / b_data  out / in / out  1 / 1 / width  to the adder b port.
- sum_vld / sum_rdy / sum_data  in / out / in  1 / 1 / width+1  from the adder sum port.
- outstanding  out  clog2(tag_depth+1)  tag FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - slot_vld=0, a_sent=0, b_sent=0, rr_ptr=0, tag FIFO empty.
  - Therefore a_vld=b_vld=0, rsp_vld=0, sum_rdy=0, outstanding=0.
  - Reset mid-operation discards the slot and all tags; the adder shares the same reset.
- Issue slot registers: a, b, tag, slot_vld, a_sent, b_sent.
  - a_vld = slot_vld & ~a_sent; b_vld = slot_vld & ~b_sent.
  - a_data and b_data come from registers only; there is no combinational path from req_* to the adder.
  - a_sent is set on an a handshake and b_sent on a b handshake. Each side may complete in any cycle, independently of the other.
- slot_free = ~slot_vld | ((a_sent | (a_vld & a_rdy)) & (b_sent | (b_vld & b_rdy))).
- load = slot_free & ~tag_full & |req_vld.
- Grant:
  - First i with req_vld[i]=1, searching from rr_ptr upward with wrap-around.
  - req_rdy[i] = load & (grant==i). At most one req_rdy is high per cycle.
  - On load: slot takes the granted operands, slot_vld=1, a_sent=b_sent=0, tag pushed to the FIFO, rr_ptr = (grant+1) mod n_req.
  - If no load occurs, rr_ptr holds.
- When the slot frees with no load, slot_vld goes to 0. Back-to-back issue is allowed when both sides complete in the same cycle as the load.
- Return path:
  - head = FIFO head tag.
  - rsp_vld[i] = sum_vld & ~tag_empty & (head==i).
  - sum_rdy = ~tag_empty & rsp_rdy[head].
  - rsp_sum = sum_data.
  - On sum_vld & sum_rdy, pop the FIFO.
- Simultaneous push and pop: occupancy is unchanged. Push is allowed when the FIFO is full only if a pop occurs the same cycle, so tag_full is evaluated as full & ~pop.
- Ordering: the adder is in-order, so FIFO order equals result order. A sum_vld while the FIFO is empty is a protocol error: sum_rdy stays 0 and the bench asserts this never occurs.
- Throughput limit: the tag FIFO bounds operations in flight to tag_depth. A stalled consumer backs up into req_rdy=0 with no loss.
- Width rule: sum is width+1 bits with no truncation; the arbiter passes it through unchanged.

Decomposition:
- Package adder_arb_pkg:
  - tag_w = clog2(n_req).
  - typedef tag_t.
  - function rr_pick(vld, ptr) returning grant and a found flag.
- Sub-module adder_arb_tag_fifo:
  - Synchronous FIFO of tag_t, depth tag_depth.
  - Ports: push, pop, full, empty, head, count.
  - Asynchronous active-low reset.

Test Plan:
- Single requester: req 2 sends a=0x05, b=0x07 once, sum_rdy path open -> rsp_vld[2] high with rsp_sum=0x00C; no other rsp_vld asserts; outstanding returns to 0.
- Fairness: all 4 requesters hold req_vld for 8 accepts -> grant order 0,1,2,3,0,1,2,3; each rsp_sum equals its own a+b.
- Overflow: a=0xFF, b=0xFF -> rsp_sum=0x1FE (9 bits).
- Skewed adder ports: b_rdy forced low 5 cycles while a_rdy=1 -> a_sent set, a_vld drops, slot holds, req_rdy all 0; on b_rdy release the pair completes and the correct sum returns.
- Backpressure and FIFO full: rsp_rdy[1]=0 while requester 1 floods -> outstanding reaches tag_depth (4), req_rdy stays 0; raising rsp_rdy[1] drains results in order with values intact.
- Reset mid-flight: rst_n pulled low asynchronously with 3 outstanding -> all vld outputs 0 immediately, outstanding=0; after release, a fresh transaction returns the correct sum.
